// File: rtl/mic1_pkg.sv
// Shared widths and types for the MIC-1 byte-serial output path.
// The CPU core's output byte mux uses the same constants.
package mic1_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned PARTIAL_W = WORD_W - BYTE_W;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mic1_word_fifo.sv
// Synchronous show-ahead word FIFO with a registered head and fill count.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module mic1_word_fifo
  import mic1_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  word_t                         push_data,
  input  logic                          pop,
  output word_t                         head,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  word_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  logic               pop_ok;
  logic               push_ok;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr_n;
  logic [CNT_W-1:0]   fill_n;
  word_t              head_n;
  logic               empty_n;
  logic               full_n;

  // Next-state: pointers, count and the entry that will sit at the head.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_n = rd_ptr + PTR_W'(pop_ok);
    wr_ptr_n = wr_ptr + PTR_W'(push_ok);
    fill_n   = fill + CNT_W'(push_ok) - CNT_W'(pop_ok);
    empty_n  = (fill_n == '0);
    full_n   = (fill_n == CNT_W'(FIFO_DEPTH));
    head_n   = head;
    if (!empty_n) begin
      // The word being written this edge becomes the head when it is the only one left.
      if (push_ok && (wr_ptr == rd_ptr_n)) begin
        head_n = push_data;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      fill   <= fill_n;
      empty  <= empty_n;
      full   <= full_n;
      head   <= head_n;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mic1_word_deserializer.sv
// Reassembles LSB-first byte lanes from the MIC-1 output port into 32-bit words
// and buffers them for a valid/ready consumer, with sticky overflow/sync flags.
module mic1_word_deserializer
  import mic1_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_W-1:0]             byte_in,
  input  logic                          byte_valid,
  input  logic                          sof,
  input  logic                          clr_flags,
  output logic [WORD_W-1:0]             word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [LANE_W-1:0]             lane,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          sync_err
);

  logic [PARTIAL_W-1:0] partial;
  logic [PARTIAL_W-1:0] partial_n;
  lane_t                lane_n;
  logic                 overflow_n;
  logic                 sync_err_n;
  logic                 push_c;
  word_t                push_word_c;
  logic                 fifo_empty;
  logic                 fifo_full;
  word_t                fifo_head;

  // Lane tracking, partial word assembly and sticky flag updates.
  always_comb begin
    lane_n      = lane;
    partial_n   = partial;
    overflow_n  = overflow;
    sync_err_n  = sync_err;
    push_c      = 1'b0;
    push_word_c = '0;

    if (clr_flags) begin
      overflow_n = 1'b0;
      sync_err_n = 1'b0;
    end

    if (byte_valid) begin
      if (sof) begin
        if (lane != '0) begin
          sync_err_n = 1'b1;
        end
        partial_n = {(PARTIAL_W - BYTE_W)'(0), byte_in};
        lane_n    = lane_t'(1);
      end else if (lane == lane_t'(LANES - 1)) begin
        push_c      = 1'b1;
        push_word_c = {byte_in, partial};
        lane_n      = '0;
      end else begin
        partial_n[BYTE_W*int'(lane) +: BYTE_W] = byte_in;
        lane_n = lane + lane_t'(1);
      end
    end

    // Dropped only when full and the consumer is not freeing a slot this edge.
    if (push_c && fifo_full && !(word_ready && !fifo_empty)) begin
      overflow_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane     <= '0;
      partial  <= '0;
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      lane     <= lane_n;
      partial  <= partial_n;
      overflow <= overflow_n;
      sync_err <= sync_err_n;
    end
  end

  mic1_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_word_c),
    .pop       (word_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .fill      (fill)
  );

  assign word_out   = fifo_head;
  assign word_valid = !fifo_empty;

endmodule

// File: tb/tb_mic1_word_deserializer.sv
// Directed self-checking bench for mic1_word_deserializer (FIFO_DEPTH = 4).
module tb_mic1_word_deserializer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sof;
  logic        clr_flags;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  lane;
  logic [2:0]  fill;
  logic        overflow;
  logic        sync_err;

  int checks;
  int errors;

  mic1_word_deserializer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .sof        (sof),
    .clr_flags  (clr_flags),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .lane       (lane),
    .fill       (fill),
    .overflow   (overflow),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    byte_in    = b;
    byte_valid = 1'b1;
    sof        = s;
    tick();
    byte_valid = 1'b0;
    sof        = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (word_out !== 32'h0) begin errors++; $display("FAIL reset_word got=%h exp=00000000", word_out); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL reset_lane got=%0d exp=0", lane); end
    checks++; if ({overflow, sync_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow, sync_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_word();
    logic [7:0] bytes [4];
    logic [1:0] exp_lane [4];
    bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
    exp_lane[0] = 2'd1; exp_lane[1] = 2'd2; exp_lane[2] = 2'd3; exp_lane[3] = 2'd0;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], i == 0);
      checks++; if (lane !== exp_lane[i]) begin errors++; $display("FAIL basic_lane%0d got=%0d exp=%0d", i, lane, exp_lane[i]); end
      if (i < 3) begin
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid%0d got=%b exp=0", i, word_valid); end
      end
    end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
    checks++; if (word_out !== 32'h12345678) begin errors++; $display("FAIL basic_word got=%h exp=12345678", word_out); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL basic_fill1 got=%0d exp=1", fill); end
    tick();
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL basic_fill0 got=%0d exp=0", fill); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", word_valid); end
    checks++; if (word_out !== 32'h12345678) begin errors++; $display("FAIL basic_hold got=%h exp=12345678", word_out); end
    // Pop on empty must be ignored.
    tick();
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL empty_pop_fill got=%0d exp=0", fill); end
  endtask

  task automatic test_gaps();
    word_ready = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    tick(); tick(); tick();
    checks++; if (lane !== 2'd2) begin errors++; $display("FAIL gap_lane got=%0d exp=2", lane); end
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    checks++; if (word_out !== 32'hDDCCBBAA) begin errors++; $display("FAIL gap_word got=%h exp=DDCCBBAA", word_out); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL gap_fill got=%0d exp=1", fill); end
    checks++; if ({overflow, sync_err} !== 2'b00) begin errors++; $display("FAIL gap_flags got=%b exp=00", {overflow, sync_err}); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL gap_pop got=%0d exp=0", fill); end
  endtask

  task automatic test_sync_err();
    word_ready = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set got=%b exp=1", sync_err); end
    checks++; if (lane !== 2'd1) begin errors++; $display("FAIL sync_lane got=%0d exp=1", lane); end
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h40, 1'b0);
    checks++; if (word_out !== 32'h40302010) begin errors++; $display("FAIL sync_word got=%h exp=40302010", word_out); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL sync_fill got=%0d exp=1", fill); end
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky got=%b exp=1", sync_err); end
    word_ready = 1'b1;
    clr_flags  = 1'b1;
    tick();
    word_ready = 1'b0;
    clr_flags  = 1'b0;
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_clear got=%b exp=0", sync_err); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL sync_pop got=%0d exp=0", fill); end
    // sof at lane 0 is silent.
    send_byte(8'h55, 1'b1);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sof_lane0 got=%b exp=0", sync_err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_overflow();
    word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_word(32'h01010101 * k);
      if (k == 3) begin
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill4 got=%0d exp=4", fill); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill_cap got=%0d exp=4", fill); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (word_out !== 32'h01010101 * k) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", k, word_out, 32'h01010101 * k); end
      tick();
    end
    word_ready = 1'b0;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", word_valid); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = 32'hA0B0C0D0 + 32'h01010101 * k;
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(w[k]);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL b2b_full got=%0d exp=4", fill); end
    for (int i = 0; i < 3; i++) send_byte(w[4][8*i +: 8], 1'b0);
    checks++; if (word_out !== w[0]) begin errors++; $display("FAIL b2b_pop0 got=%h exp=%h", word_out, w[0]); end
    word_ready = 1'b1;
    send_byte(w[4][31:24], 1'b0);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL b2b_fill got=%0d exp=4", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    for (int k = 1; k < 5; k++) begin
      checks++; if (word_out !== w[k]) begin errors++; $display("FAIL b2b_pop%0d got=%h exp=%h", k, word_out, w[k]); end
      tick();
    end
    word_ready = 1'b0;
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", fill); end
  endtask

  task automatic test_reset_midword();
    word_ready = 1'b0;
    send_word(32'h11223344);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rst_pre_fill got=%0d exp=1", fill); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", word_valid); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_mid_fill got=%0d exp=0", fill); end
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL rst_mid_lane got=%0d exp=0", lane); end
    send_word(32'hDEADBEEF);
    checks++; if (word_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_clean_word got=%h exp=DEADBEEF", word_out); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rst_clean_fill got=%0d exp=1", fill); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sof        = 1'b0;
    clr_flags  = 1'b0;
    word_ready = 1'b0;
    #2;
    test_reset();
    test_basic_word();
    test_gaps();
    test_sync_err();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic1_word_deserializer.md
Name: mic1_word_deserializer

Overview:
- Receive-side counterpart of the MIC-1 byte-serial output port.
- The CPU core drives one 8-bit lane of a 32-bit register per cycle, least-significant byte first (lane 0 = [7:0] … lane 3 = [31:24]).
- This block reassembles those bytes into 32-bit words and buffers them in a small FIFO.
- It presents the words on a valid/ready interface to downstream logic (debug capture, memory-side host bridge).

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words buffered; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- byte_in  input  8  incoming byte; lane given by the internal lane counter.
- byte_valid  input  1  byte_in is valid this cycle; always accepted, no back-pressure on the byte side.
- sof  input  1  start-of-word; qualified by byte_valid, forces this byte into lane 0.
- clr_flags  input  1  synchronous clear of the sticky flags.
- word_out  output  32  FIFO head word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts word_out when word_valid is also high.
- lane  output  2  lane the next accepted byte will occupy.
- fill  output  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- sync_err  output  1  sticky; sof arrived while lane != 0, so a partial word was discarded.

Behaviour:
- Reset (rst_n low at a clock edge):
  - lane=0, partial shift register=0, FIFO empty.
  - word_valid=0, word_out=0, fill=0, overflow=0, sync_err=0.
  - Reset mid-word discards the partial word; reset with the FIFO non-empty discards all stored words.
- Byte accept (byte_valid=1):
  - Byte goes into partial[8*lane +: 8]; lane increments and wraps 3→0.
  - When sof=1: the byte goes into lane 0 and lane becomes 1.
    - If lane was not 0, the partial word is discarded and sync_err is set.
    - sof with lane==0 is legal and silent.
- Byte idle (byte_valid=0): no state change; gaps between bytes are allowed at any lane.
- Word completion: when the accepted byte lands in lane 3, the word {byte_in, partial[23:0]} is pushed to the FIFO at that same edge.
- Latency: with the FIFO empty, word_valid rises the cycle after the lane-3 byte edge, and word_out equals the assembled word.
- Pop: word_valid & word_ready at an edge removes the head. word_out shows the next entry in the following cycle, or holds its last value with word_valid=0 when the FIFO becomes empty.
- Push/pop per cycle:
  - A push is accepted if fill < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Simultaneous push and pop leaves fill unchanged.
  - Push with the FIFO full and no pop: the word is dropped, overflow is set, and FIFO contents are unchanged.
- Pop on an empty FIFO is ignored (word_ready without word_valid has no effect).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- fill is registered, updated on the same edge as push/pop, and never exceeds FIFO_DEPTH.
- clr_flags clears overflow and sync_err. If a set event occurs in the same cycle, set wins.
- No combinational path from byte_in/byte_valid to word_out/word_valid. word_ready reaches only the FIFO state, not outputs, in the same cycle.

Decomposition:
- Package mic1_pkg holds:
  - BYTE_W=8, WORD_W=32, LANES=4.
  - typedef lane_t (2-bit).
  - typedef word_t (32-bit).
  - These constants are shared with the CPU core's output byte mux.
- One sub-module, mic1_word_fifo: a synchronous show-ahead FIFO parameterised by FIFO_DEPTH.
  - Ports: push, push_data, pop, head, empty, full, fill.
  - It implements the accept-when-full-if-pop rule.
- The top level keeps the lane counter, partial register and sticky flags.

Test Plan:
- Reset, then 4 bytes 0x78,0x56,0x34,0x12 with sof on the first and word_ready=1 → word_valid high one cycle after the 4th byte, word_out=0x12345678, fill returns to 0, lane sequence 1,2,3,0.
- Bytes 0xAA,0xBB, idle 3 cycles, 0xCC,0xDD → single word 0xDDCCBBAA; no flags set.
- Bytes 0x01,0x02, then sof with 0x10, followed by 0x20,0x30,0x40 → sync_err=1, only word 0x40302010 emitted; clr_flags → sync_err=0.
- word_ready=0, push 5 words 0x00000000..0x04040404 (FIFO_DEPTH=4) → fill=4, overflow=1 after 5th, popped sequence is words 0–3 only, in order.
- FIFO full with word_ready=1 on the same cycle the 5th word completes → no overflow, fill stays 4, all 5 words later pop in order.
- rst_n low after 2 bytes with 1 word queued → word_valid=0, fill=0, lane=0; next 4 bytes form a clean word.
